// File: rtl/dog_pkg.sv
// Shared widths, output-mode encoding and saturation helper for the DoG stage.
package dog_pkg;

    localparam int PIX_W    = 8;
    localparam int DIFF_W   = 9;
    localparam int SCALED_W = 11;
    localparam int CNT_W    = 19;

    typedef enum logic {
        MODE_ABS    = 1'b0,
        MODE_OFFSET = 1'b1
    } out_mode_e;

    // Clamp a signed value (one bit wider than the scaled difference) into 0..255.
    function automatic logic [PIX_W-1:0] sat_u8(input logic signed [SCALED_W:0] v);
        if (v < 0)
            return '0;
        else if (v > (SCALED_W+1)'(255))
            return 8'hff;
        else
            return v[PIX_W-1:0];
    endfunction

endpackage

// File: rtl/pixel_fifo.sv
// First-word fall-through pixel FIFO; the head entry is visible combinationally
// so the consumer can pop and use the data on the same edge.
module pixel_fifo
    import dog_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     wr_en,
    input  logic [PIX_W-1:0]         din,
    input  logic                     rd_en,
    output logic [PIX_W-1:0]         dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [PIX_W-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             wr_ok;
    logic             rd_ok;

    // A full FIFO still takes a write when the head leaves on the same edge.
    assign wr_ok = wr_en && !clear && (!full || rd_en);
    assign rd_ok = rd_en && !clear && !empty;

    assign dout  = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == (AW+1)'(DEPTH));

    // Storage array, no reset needed: pointers define what is valid.
    always_ff @(posedge clock) begin
        if (wr_ok)
            mem[wr_ptr] <= din;
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/dog_stream_subtractor.sv
// Difference-of-Gaussians stage: aligns two pixel streams, subtracts pairwise,
// scales/formats to 8 bits and presents the result under ready/valid.
module dog_stream_subtractor
    import dog_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int N_PIXEL     = 480000,
    parameter int SHIFT       = 0,
    parameter int OFFSET_MODE = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    input  logic              a_valid,
    input  logic [PIX_W-1:0]  a_pixel,
    input  logic              b_valid,
    input  logic [PIX_W-1:0]  b_pixel,
    output logic [PIX_W-1:0]  dout,
    output logic              valid,
    input  logic              ready,
    output logic              done,
    output logic              overflow,
    output logic [CNT_W-1:0]  pixel_count
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic signed [SCALED_W:0] S_MAX = (SCALED_W+1)'(1023);
    localparam logic signed [SCALED_W:0] S_MIN = -(SCALED_W+1)'(1024);

    logic              a_empty, a_full, b_empty, b_full;
    logic [PIX_W-1:0]  a_head, b_head;
    logic [CW-1:0]     a_count, b_count;
    logic              unused_counts;
    logic              pop;
    logic              accept;

    logic signed [DIFF_W-1:0]   diff;
    logic signed [SCALED_W:0]   wide;
    logic signed [SCALED_W-1:0] s;
    logic signed [SCALED_W:0]   s_ext;
    logic signed [SCALED_W:0]   mag;
    logic [PIX_W-1:0]           fmt;

    assign unused_counts = ^{a_count, b_count};

    // Both heads leave together, only when the output slot is free or draining.
    assign pop    = !a_empty && !b_empty && (!valid || ready) && !clear;
    assign accept = valid && ready && !clear;

    pixel_fifo #(.DEPTH(DEPTH)) u_fifo_a (
        .clock (clock), .reset (reset), .clear (clear),
        .wr_en (a_valid), .din (a_pixel), .rd_en (pop),
        .dout  (a_head), .empty (a_empty), .full (a_full), .count (a_count)
    );

    pixel_fifo #(.DEPTH(DEPTH)) u_fifo_b (
        .clock (clock), .reset (reset), .clear (clear),
        .wr_en (b_valid), .din (b_pixel), .rd_en (pop),
        .dout  (b_head), .empty (b_empty), .full (b_full), .count (b_count)
    );

    // Subtract, apply gain and format. The shift is done one bit wide and then
    // clamped into the 11-bit range so SHIFT=3 cannot wrap the sign.
    always_comb begin
        diff  = $signed({1'b0, a_head}) - $signed({1'b0, b_head});
        wide  = (SCALED_W+1)'(diff) <<< SHIFT;
        if (wide > S_MAX)
            s = SCALED_W'(S_MAX);
        else if (wide < S_MIN)
            s = SCALED_W'(S_MIN);
        else
            s = SCALED_W'(wide);
        s_ext = (SCALED_W+1)'(s);
        mag   = (s_ext < 0) ? -s_ext : s_ext;
        if (OFFSET_MODE == int'(MODE_OFFSET))
            fmt = sat_u8(s_ext + (SCALED_W+1)'(128));
        else
            fmt = sat_u8(mag);
    end

    // Output register: load on pop, drop valid once taken, hold under backpressure.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dout  <= '0;
            valid <= 1'b0;
        end else if (clear) begin
            dout  <= '0;
            valid <= 1'b0;
        end else if (pop) begin
            dout  <= fmt;
            valid <= 1'b1;
        end else if (accept) begin
            valid <= 1'b0;
        end
    end

    // Frame counter with single-cycle done pulse on the last pixel.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pixel_count <= '0;
            done        <= 1'b0;
        end else if (clear) begin
            pixel_count <= '0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                if (pixel_count == CNT_W'(N_PIXEL - 1)) begin
                    pixel_count <= '0;
                    done        <= 1'b1;
                end else begin
                    pixel_count <= pixel_count + 1'b1;
                end
            end
        end
    end

    // Sticky overflow: a pixel arrived at a full FIFO with no pop to make room.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            overflow <= 1'b0;
        else if (clear)
            overflow <= 1'b0;
        else if ((a_valid && a_full && !pop) || (b_valid && b_full && !pop))
            overflow <= 1'b1;
    end

endmodule

// File: tb/tb_dog_stream_subtractor.sv
// Directed bench: dut0 is |a-b| with no gain and a 64-pixel frame, dut1 is the
// offset format with gain 4. Both see the same stimulus.
module tb_dog_stream_subtractor;

    logic        clock = 1'b0;
    logic        reset, clear, a_valid, b_valid, ready;
    logic [7:0]  a_pixel, b_pixel;
    logic [7:0]  dout0, dout1;
    logic        valid0, valid1, done0, done1, ovf0, ovf1;
    logic [18:0] cnt0, cnt1;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clock = ~clock;

    dog_stream_subtractor #(.DEPTH(16), .N_PIXEL(64), .SHIFT(0), .OFFSET_MODE(0)) dut0 (
        .clock(clock), .reset(reset), .clear(clear),
        .a_valid(a_valid), .a_pixel(a_pixel), .b_valid(b_valid), .b_pixel(b_pixel),
        .dout(dout0), .valid(valid0), .ready(ready), .done(done0),
        .overflow(ovf0), .pixel_count(cnt0)
    );

    dog_stream_subtractor #(.DEPTH(16), .N_PIXEL(480000), .SHIFT(2), .OFFSET_MODE(1)) dut1 (
        .clock(clock), .reset(reset), .clear(clear),
        .a_valid(a_valid), .a_pixel(a_pixel), .b_valid(b_valid), .b_pixel(b_pixel),
        .dout(dout1), .valid(valid1), .ready(ready), .done(done1),
        .overflow(ovf1), .pixel_count(cnt1)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] e_abs;   // |a-b|
        logic [7:0] e_off;   // clamp(4*(a-b)+128)
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Advance one clock; outputs are sampled and inputs changed 1 ns after the edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_clear();
        a_valid = 1'b0; b_valid = 1'b0;
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    initial begin
        int got;
        int accepts;
        int dones;
        logic [7:0] prev_d;
        logic       prev_hold;

        vecs[0] = '{8'd200, 8'd50,  8'd150, 8'd255};
        vecs[1] = '{8'd10,  8'd30,  8'd20,  8'd48};
        vecs[2] = '{8'd100, 8'd90,  8'd10,  8'd168};
        vecs[3] = '{8'd0,   8'd255, 8'd255, 8'd0};
        vecs[4] = '{8'd255, 8'd0,   8'd255, 8'd255};
        vecs[5] = '{8'd77,  8'd77,  8'd0,   8'd128};
        vecs[6] = '{8'd120, 8'd100, 8'd20,  8'd208};
        vecs[7] = '{8'd50,  8'd82,  8'd32,  8'd0};
        vecs[8] = '{8'd60,  8'd91,  8'd31,  8'd4};

        reset = 1'b1; clear = 1'b0; ready = 1'b1;
        a_valid = 1'b0; b_valid = 1'b0; a_pixel = '0; b_pixel = '0;
        step(); step();
        chk("reset_valid", int'(valid0), 0);
        chk("reset_dout", int'(dout0), 0);
        chk("reset_done", int'(done0), 0);
        chk("reset_overflow", int'(ovf0), 0);
        chk("reset_count", int'(cnt0), 0);
        reset = 1'b0;
        step();

        // Single pairs: written at one edge, visible after the next, taken on the third.
        for (int i = 0; i < 9; i++) begin
            a_pixel = vecs[i].a; b_pixel = vecs[i].b;
            a_valid = 1'b1; b_valid = 1'b1; ready = 1'b1;
            step();
            a_valid = 1'b0; b_valid = 1'b0;
            step();
            chk("vec_valid", int'(valid0), 1);
            chk("vec_abs", int'(dout0), int'(vecs[i].e_abs));
            chk("vec_offset", int'(dout1), int'(vecs[i].e_off));
            step();
            chk("vec_drained", int'(valid0), 0);
        end

        // Skew + backpressure: ramp issued every other cycle so the half-duty
        // ready can keep up; B trails A by 8 cycles.
        do_clear();
        got = 0; prev_hold = 1'b0; prev_d = '0;
        for (int c = 0; c < 110; c++) begin
            a_valid = (c < 64) && (c % 2 == 0);
            a_pixel = 8'(8 * (c / 2));
            b_valid = (c >= 8) && (c < 72) && (c % 2 == 0);
            b_pixel = 8'(3 * ((c - 8) / 2));
            ready   = ((c / 3) % 2 == 0);
            if (prev_hold) begin
                chk("skew_hold_valid", int'(valid0), 1);
                chk("skew_hold_dout", int'(dout0), int'(prev_d));
            end
            if (valid0 && ready) begin
                chk("skew_value", int'(dout0), 5 * got);
                got++;
            end
            prev_hold = valid0 && !ready;
            prev_d    = dout0;
            step();
        end
        a_valid = 1'b0; b_valid = 1'b0; ready = 1'b1;
        chk("skew_count", got, 32);
        chk("skew_overflow", int'(ovf0), 0);

        // Overflow: 17 A pixels into a 16-deep FIFO, then 16 B pixels.
        do_clear();
        ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            a_valid = 1'b1; a_pixel = 8'(10 + i);
            step();
            if (i == 15) chk("ovf_not_yet", int'(ovf0), 0);
        end
        a_valid = 1'b0;
        chk("ovf_set", int'(ovf0), 1);
        got = 0;
        for (int c = 0; c < 40; c++) begin
            b_valid = (c < 16); b_pixel = 8'd0;
            if (valid0 && ready) begin
                chk("ovf_value", int'(dout0), 10 + got);
                got++;
            end
            step();
        end
        b_valid = 1'b0;
        chk("ovf_out_count", got, 16);
        chk("ovf_sticky", int'(ovf0), 1);

        // Frame: 64 continuous pairs against N_PIXEL=64.
        do_clear();
        ready = 1'b1; accepts = 0; dones = 0;
        for (int c = 0; c < 80; c++) begin
            a_valid = (c < 64); a_pixel = 8'(c);
            b_valid = (c < 64); b_pixel = 8'd0;
            if (done0) begin
                dones++;
                chk("frame_done_at_64", accepts, 64);
                chk("frame_wrap", int'(cnt0), 0);
            end
            if (valid0 && ready) accepts++;
            step();
        end
        a_valid = 1'b0; b_valid = 1'b0;
        chk("frame_done_pulses", dones, 1);
        chk("frame_accepts", accepts, 64);
        chk("frame_count_end", int'(cnt0), 0);

        // Clear mid-frame with both FIFOs holding data and overflow set.
        do_clear();
        ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            a_valid = 1'b1; b_valid = 1'b1; a_pixel = 8'(i + 1); b_pixel = 8'd0;
            step();
        end
        b_valid = 1'b0; ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            a_pixel = 8'(50 + i);
            step();
        end
        chk("pre_clear_overflow", int'(ovf0), 1);
        chk("pre_clear_valid", int'(valid0), 1);
        chk("pre_clear_count_nz", int'(cnt0 != 0), 1);
        a_valid = 1'b1; b_valid = 1'b1; ready = 1'b1; clear = 1'b1;
        step();
        clear = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
        chk("clear_valid", int'(valid0), 0);
        chk("clear_count", int'(cnt0), 0);
        chk("clear_overflow", int'(ovf0), 0);
        chk("clear_done", int'(done0), 0);
        a_pixel = 8'd99; b_pixel = 8'd33; a_valid = 1'b1; b_valid = 1'b1;
        step();
        a_valid = 1'b0; b_valid = 1'b0;
        step();
        chk("post_clear_valid", int'(valid0), 1);
        chk("post_clear_dout", int'(dout0), 66);
        step();
        chk("post_clear_empty", int'(valid0), 0);

        // Asynchronous reset mid-frame takes effect without a clock edge.
        ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            a_valid = 1'b1; b_valid = 1'b1; a_pixel = 8'(20 + i); b_pixel = 8'd5;
            step();
        end
        a_valid = 1'b0; b_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("arst_valid", int'(valid0), 0);
        chk("arst_dout", int'(dout0), 0);
        chk("arst_count", int'(cnt0), 0);
        step();
        reset = 1'b0; ready = 1'b1;
        a_pixel = 8'd200; b_pixel = 8'd50; a_valid = 1'b1; b_valid = 1'b1;
        step();
        a_valid = 1'b0; b_valid = 1'b0;
        step();
        chk("post_arst_valid", int'(valid0), 1);
        chk("post_arst_dout", int'(dout0), 150);
        step();
        chk("post_arst_empty", int'(valid0), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dog_stream_subtractor.md
# dog_stream_subtractor

Difference-of-Gaussians stage for the SIFT scale-space pipeline. It consumes two 8-bit pixel streams of the same frame: a blur level k, for example the GaussianWrapper output, and a blur level k+1, or the unblurred static image / VGA pixel stream. It aligns the two streams in per-stream FIFOs, subtracts them pairwise, scales and formats the result, and presents an 8-bit DoG pixel stream to the ImageBufferWriter video input under a ready/valid handshake. It also counts output pixels per frame and flags input overflow.

## Interface
Parameters:
- DEPTH, 16: entries per input FIFO; power of two, ≥ 4.
- N_PIXEL, 480000: output pixels per frame.
- SHIFT, 0: left-shift gain applied to the difference (0–3), with saturation.
- OFFSET_MODE, 0: output format. 0 gives |a−b|. 1 gives signed (a−b) biased by 128.

Ports:
- clock, in, 1: sole clock; all logic is on the rising edge.
- reset, in, 1: asynchronous, active-high.
- clear, in, 1: synchronous frame restart; empties FIFOs, drops output, zeroes count, clears overflow.
- a_valid, in, 1: a_pixel is valid this cycle. Stream A has no backpressure.
- a_pixel, in, 8: stream A pixel (minuend).
- b_valid, in, 1: b_pixel is valid this cycle. Stream B has no backpressure.
- b_pixel, in, 8: stream B pixel (subtrahend).
- dout, out, 8: DoG pixel.
- valid, out, 1: dout is valid.
- ready, in, 1: downstream accepts dout.
- done, out, 1: one-cycle pulse when pixel N_PIXEL of the frame is accepted.
- overflow, out, 1: sticky; an input pixel was dropped.
- pixel_count, out, 19: output pixels accepted so far in the current frame.

## Operation
- **Reset values:** dout=0, valid=0, done=0, overflow=0, pixel_count=0, both FIFOs empty.
- **FIFO write:**
  - x_valid writes x_pixel when occupancy < DEPTH, or when a pop happens in the same cycle.
  - Otherwise the pixel is dropped and overflow is set.
  - overflow stays set until reset or clear.
- **Pop condition:** pop = both FIFOs non-empty AND (valid==0 OR ready==1). Both FIFOs pop together; they never pop individually.
- **Arithmetic:**
  - d = a − b as 9-bit signed.
  - d is shifted left by SHIFT into an 11-bit signed value s.
- **Formatting:**
  - OFFSET_MODE 0: dout = min(|s|, 255).
  - OFFSET_MODE 1: dout = clamp(s + 128, 0, 255).
- **Output register:**
  - On a pop, dout and valid=1 are loaded.
  - If valid && ready and there is no pop, valid is cleared.
  - If valid && !ready, dout and valid hold unchanged.
- **Frame counter:**
  - Each accepted output (valid && ready) increments pixel_count.
  - When the accepted pixel brings the count to N_PIXEL, done pulses for one cycle and pixel_count wraps to 0.
- **clear:** overrides all same-cycle writes, pops and accepts. The next cycle equals the post-reset state.
- **Asynchronous reset mid-frame:** all state is lost and the block is in the reset state immediately.

## Timing
- **Latency:** with both FIFOs empty and a_valid & b_valid high at edge k, valid is high after edge k+1 with the corresponding dout.
- **Throughput:** one pair per cycle while ready stays high.
- **Skewed streams:** if stream B lags stream A by L cycles (L ≤ DEPTH), the output for pair i appears one edge after B's pixel i is written. Nothing is dropped.
- **Full FIFO:** a write into a full FIFO in a cycle with a pop succeeds. A write into a full FIFO without a pop drops the pixel; overflow rises after that edge.
- **Flag timing:** done and overflow are registered and update on the edge after their cause.

## Structure
- **Shared package dog_pkg:**
  - PIX_W=8, DIFF_W=9, SCALED_W=11, CNT_W=19.
  - Output mode enum: MODE_ABS=0, MODE_OFFSET=1.
- **Sub-module pixel_fifo:**
  - Synchronous FIFO with parameters DEPTH and width 8, instantiated twice.
  - Ports: clock, reset, clear, wr_en, din, rd_en, dout, empty, full, count.
  - Read data is available combinationally (first-word fall-through) so that a pop and the output register load happen on the same edge.
- **Top level:** pop logic, arithmetic, output register and frame counter. Target size is 150–250 lines of RTL.

## Test plan
- **Basic pair, OFFSET_MODE 0, SHIFT 0:** a=200 and b=50 written at the same edge, ready=1 → valid after 1 edge, dout=150. Then a=10, b=30 → dout=20.
- **OFFSET_MODE 1, SHIFT 2:** a=100, b=90 gives s=40 → dout=168. a=0, b=255 gives s=−1020 → dout=0 (clamped).
- **Skew and backpressure:** B delayed 8 cycles relative to A on a 32-pixel ramp, ready toggled every 3 cycles → all 32 outputs appear in order with correct values, overflow=0, and dout is stable whenever ready=0.
- **Overflow:** DEPTH=16, only A driven for 17 cycles → overflow=1 after the 17th edge. B then supplies 16 pixels → exactly 16 outputs.
- **Frame count:** N_PIXEL=64 with 64 continuous pairs → done pulses for exactly 1 cycle on the 64th accept, and pixel_count returns to 0.
- **Clear and reset mid-frame:** after 10 pairs, assert clear (or reset) with both FIFOs non-empty → the next cycle has valid=0, pixel_count=0, overflow=0, and a fresh pair produces an output 1 edge later.
